duty_config_ctrl: RTL and testbench

DUTY_CONFIG_CTRL -- requirements
Module: duty_config_ctrl

---
 rtl/duty_config_ctrl_pkg.sv | 51 +++++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/duty_config_ctrl.sv | 157 +++++++++++++++
 tb/tb_duty_config_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_config_ctrl_pkg.sv
// Shared types, encodings and helpers for the duty configuration controller.
package duty_config_ctrl_pkg;

    localparam int DUTY_MAX_DEFAULT = 10;
    localparam int DUTY_W           = 4;

    // Colour selector as presented on H1.
    typedef enum logic [1:0] {
        H1_NONE  = 2'b00,
        H1_RED   = 2'b01,
        H1_GREEN = 2'b10,
        H1_BLUE  = 2'b11
    } h1_t;

    // Auto-repeat stepping engine states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } step_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Next colour in the none -> red -> green -> blue -> none cycle.
    function automatic h1_t h1_next(input h1_t cur);
        logic [1:0] nxt;
        nxt = cur + 2'b01;
        return h1_t'(nxt);
    endfunction

    // One saturating duty step; a step at the limit returns the value unchanged.
    function automatic logic [DUTY_W-1:0] duty_step(input logic [DUTY_W-1:0] cur,
                                                    input logic              up,
                                                    input logic [DUTY_W-1:0] lim);
        logic [DUTY_W-1:0] res;
        res = cur;
        if (up) begin
            if (cur < lim) res = cur + 1'b1;
        end else begin
            if (cur != '0) res = cur - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, tick-based debounce, press pulse.
module btn_debounce #(
    parameter int DEB_TICKS = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic ce_in,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEB_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q,   deb_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Count consecutive ticks where the synchronized level disagrees; toggle on the last one.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (ce_in) begin
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d   = ~deb_q;
                    cnt_d   = '0;
                    press_d = ~deb_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State registers; reset clears the synchronizer so a held button must re-qualify.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = deb_q;
    assign press = press_q;

endmodule

// File: rtl/duty_config_ctrl.sv
// RGB duty configuration: colour select plus up/down stepping with auto-repeat.
module duty_config_ctrl
    import duty_config_ctrl_pkg::*;
#(
    parameter int DEB_TICKS = 8,
    parameter int RPT_DELAY = 50,
    parameter int RPT_RATE  = 10,
    parameter int DUTY_MAX  = DUTY_MAX_DEFAULT
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              CE_IN,
    input  logic              BTN_SEL,
    input  logic              BTN_UP,
    input  logic              BTN_DN,
    output logic [1:0]        H1,
    output logic [DUTY_W-1:0] RED_DUTY,
    output logic [DUTY_W-1:0] GREEN_DUTY,
    output logic [DUTY_W-1:0] BLUE_DUTY,
    output logic              CHG
);

    localparam int                CNT_MAX    = max3(RPT_DELAY, RPT_RATE, DEB_TICKS);
    localparam int                CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  DELAY_LOAD = CNT_W'(RPT_DELAY);
    localparam logic [CNT_W-1:0]  RATE_LOAD  = CNT_W'(RPT_RATE);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_LIM   = DUTY_W'(DUTY_MAX);

    logic sel_level_unused, sel_press;
    logic up_lvl, up_press;
    logic dn_lvl, dn_press;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_sel (
        .clk(CLK), .clr(CLR), .ce_in(CE_IN), .btn_raw(BTN_SEL),
        .level(sel_level_unused), .press(sel_press)
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_up (
        .clk(CLK), .clr(CLR), .ce_in(CE_IN), .btn_raw(BTN_UP),
        .level(up_lvl), .press(up_press)
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_dn (
        .clk(CLK), .clr(CLR), .ce_in(CE_IN), .btn_raw(BTN_DN),
        .level(dn_lvl), .press(dn_press)
    );

    step_state_t       st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_up_q, dir_up_d;
    h1_t               h1_q, h1_d;
    logic [DUTY_W-1:0] red_q, red_d;
    logic [DUTY_W-1:0] green_q, green_d;
    logic [DUTY_W-1:0] blue_q, blue_d;
    logic              chg_q, chg_d;

    logic step_en;
    logic step_up;
    logic held_lvl;
    logic opp_lvl;

    // Stepping engine: first step on press, delayed first repeat, then fixed-rate repeats.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        step_en  = 1'b0;
        step_up  = dir_up_q;
        held_lvl = dir_up_q ? up_lvl : dn_lvl;
        opp_lvl  = dir_up_q ? dn_lvl : up_lvl;
        unique case (st_q)
            ST_IDLE: begin
                // A simultaneous press of both sees the other level high and is ignored.
                if (up_press && !dn_lvl) begin
                    step_en  = 1'b1;
                    step_up  = 1'b1;
                    dir_up_d = 1'b1;
                    cnt_d    = DELAY_LOAD;
                    st_d     = ST_DELAY;
                end else if (dn_press && !up_lvl) begin
                    step_en  = 1'b1;
                    step_up  = 1'b0;
                    dir_up_d = 1'b0;
                    cnt_d    = DELAY_LOAD;
                    st_d     = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!held_lvl || opp_lvl) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else if (CE_IN) begin
                    if (cnt_q <= CNT_ONE) begin
                        step_en = 1'b1;
                        cnt_d   = RATE_LOAD;
                        st_d    = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Apply steps to the colour selected before any same-cycle SEL advance.
    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        h1_d    = sel_press ? h1_next(h1_q) : h1_q;
        if (step_en) begin
            unique case (h1_q)
                H1_RED:   red_d   = duty_step(red_q,   step_up, DUTY_LIM);
                H1_GREEN: green_d = duty_step(green_q, step_up, DUTY_LIM);
                H1_BLUE:  blue_d  = duty_step(blue_q,  step_up, DUTY_LIM);
                default:  ;
            endcase
        end
        chg_d = (red_d != red_q) || (green_d != green_q) ||
                (blue_d != blue_q) || (h1_d != h1_q);
    end

    // Registered engine state and outputs.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            dir_up_q <= 1'b0;
            h1_q     <= H1_NONE;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            chg_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            h1_q     <= h1_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            chg_q    <= chg_d;
        end
    end

    assign H1         = h1_q;
    assign RED_DUTY   = red_q;
    assign GREEN_DUTY = green_q;
    assign BLUE_DUTY  = blue_q;
    assign CHG        = chg_q;

endmodule

// File: tb/tb_duty_config_ctrl.sv
// Bench for duty_config_ctrl: directed scenarios plus random buttons vs a behavioural model.
module tb_duty_config_ctrl;

    localparam int DEB    = 8;
    localparam int DLY    = 50;
    localparam int RATE   = 10;
    localparam int DMAX   = 10;
    localparam int CE_DIV = 4;

    logic       CLK = 1'b0;
    logic       CLR, CE_IN, BTN_SEL, BTN_UP, BTN_DN;
    logic [1:0] H1;
    logic [3:0] RED_DUTY, GREEN_DUTY, BLUE_DUTY;
    logic       CHG;

    duty_config_ctrl #(
        .DEB_TICKS(DEB), .RPT_DELAY(DLY), .RPT_RATE(RATE), .DUTY_MAX(DMAX)
    ) dut (
        .CLK(CLK), .CLR(CLR), .CE_IN(CE_IN),
        .BTN_SEL(BTN_SEL), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN),
        .H1(H1), .RED_DUTY(RED_DUTY), .GREEN_DUTY(GREEN_DUTY),
        .BLUE_DUTY(BLUE_DUTY), .CHG(CHG)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int ce_phase = 0;
    bit rand_ce = 1'b0;
    int chg_seen = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons: 0 = SEL, 1 = UP, 2 = DN. Duties: 0 = red, 1 = green, 2 = blue.
    int m_seen[3][2];   // raw level sampled one and two edges ago
    int m_deb[3];       // debounced level
    int m_run[3];       // consecutive disagreeing ticks
    int m_evt[3];       // press event visible this cycle
    int m_h1;
    int m_duty[3];
    int m_mode;         // 0 idle, 1 waiting first repeat, 2 repeating
    int m_left;         // ticks until the next repeat step
    int m_dir;          // +1 up, -1 down
    int m_chg;

    function automatic int clamp_duty(input int v);
        if (v < 0) return 0;
        if (v > DMAX) return DMAX;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_seen[i][0] = 0; m_seen[i][1] = 0;
            m_deb[i] = 0; m_run[i] = 0; m_evt[i] = 0; m_duty[i] = 0;
        end
        m_h1 = 0; m_mode = 0; m_left = 0; m_dir = 1; m_chg = 0;
    endtask

    task automatic model_edge(input bit ce, input bit r_sel, input bit r_up, input bit r_dn);
        int step, held, opp, old_h1, changed;
        int old_duty[3];
        int raw[3];
        raw[0] = r_sel; raw[1] = r_up; raw[2] = r_dn;
        old_duty = m_duty;
        old_h1 = m_h1;
        step = 0;
        if (m_mode == 0) begin
            if (m_evt[1] != 0 && m_deb[2] == 0) begin
                step = 1; m_dir = 1; m_left = DLY; m_mode = 1;
            end else if (m_evt[2] != 0 && m_deb[1] == 0) begin
                step = -1; m_dir = -1; m_left = DLY; m_mode = 1;
            end
        end else begin
            held = (m_dir > 0) ? 1 : 2;
            opp  = 3 - held;
            if (m_deb[held] == 0 || m_deb[opp] != 0) begin
                m_mode = 0; m_left = 0;
            end else if (ce) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    step = m_dir; m_left = RATE; m_mode = 2;
                end
            end
        end
        if (step != 0 && old_h1 != 0)
            m_duty[old_h1-1] = clamp_duty(m_duty[old_h1-1] + step);
        if (m_evt[0] != 0) m_h1 = (m_h1 + 1) % 4;
        for (int i = 0; i < 3; i++) begin
            m_evt[i] = 0;
            if (ce) begin
                if (m_seen[i][1] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = 1 - m_deb[i];
                        m_run[i] = 0;
                        m_evt[i] = m_deb[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_seen[i][1] = m_seen[i][0];
            m_seen[i][0] = raw[i];
        end
        changed = (m_h1 != old_h1) ? 1 : 0;
        for (int i = 0; i < 3; i++)
            if (m_duty[i] != old_duty[i]) changed = 1;
        m_chg = changed;
    endtask

    task automatic check_outputs();
        check_val("h1",    int'(H1),         m_h1);
        check_val("red",   int'(RED_DUTY),   m_duty[0]);
        check_val("green", int'(GREEN_DUTY), m_duty[1]);
        check_val("blue",  int'(BLUE_DUTY),  m_duty[2]);
        check_val("chg",   int'(CHG),        m_chg);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(negedge CLK);
        if (rand_ce) CE_IN = ($urandom_range(0, 3) == 0);
        else         CE_IN = (ce_phase == CE_DIV - 1);
        ce_phase = (ce_phase + 1) % CE_DIV;
        @(posedge CLK);
        if (CLR) model_reset();
        else     model_edge(CE_IN, BTN_SEL, BTN_UP, BTN_DN);
        #1;
        check_outputs();
        if (CHG) chg_seen++;
    endtask

    task automatic ticks(input int n);
        repeat (n * CE_DIV) cycle();
    endtask

    task automatic set_btn(input int idx, input bit v);
        case (idx)
            0: BTN_SEL = v;
            1: BTN_UP  = v;
            default: BTN_DN = v;
        endcase
    endtask

    task automatic tap(input int idx);
        set_btn(idx, 1'b1); ticks(10);
        set_btn(idx, 1'b0); ticks(10);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_clr();
        #2 CLR = 1'b1;
        #1 model_reset();
        check_outputs();
        repeat (3) cycle();
        CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; CE_IN = 1'b0; BTN_SEL = 1'b0; BTN_UP = 1'b0; BTN_DN = 1'b0;
        model_reset();
        repeat (3) cycle();
        CLR = 1'b0;
        cycle();
        check_val("rst_h1", int'(H1), 0);
        check_val("rst_red", int'(RED_DUTY), 0);

        // Bouncy SEL presses: each qualifies exactly once.
        chg_seen = 0;
        for (int k = 1; k <= 4; k++) begin
            for (int b = 0; b < 3; b++) begin
                BTN_SEL = (b % 2 == 0); ticks(1);
            end
            BTN_SEL = 1'b1; ticks(10);
            BTN_SEL = 1'b0; ticks(10);
            check_val("sel_seq", int'(H1), k % 4);
        end
        check_val("sel_chg_count", chg_seen, 4);

        // Red to 9 with taps, then a long hold saturates after one change.
        tap(0);
        for (int k = 0; k < 9; k++) tap(1);
        check_val("red_nine", int'(RED_DUTY), 9);
        chg_seen = 0;
        BTN_UP = 1'b1; ticks(100);
        BTN_UP = 1'b0; ticks(12);
        check_val("red_sat", int'(RED_DUTY), DMAX);
        check_val("red_sat_chg", chg_seen, 1);

        // Green from 0: press step plus repeats at +50, +60, +70.
        tap(0);
        chg_seen = 0;
        BTN_UP = 1'b1; ticks(75);
        BTN_UP = 1'b0; ticks(12);
        check_val("green_rpt", int'(GREEN_DUTY), 4);
        check_val("green_rpt_chg", chg_seen, 4);

        // Blue at 5, both buttons together do nothing.
        tap(0);
        for (int k = 0; k < 5; k++) tap(1);
        chg_seen = 0;
        BTN_UP = 1'b1; BTN_DN = 1'b1; ticks(20);
        BTN_UP = 1'b0; BTN_DN = 1'b0; ticks(12);
        check_val("blue_both", int'(BLUE_DUTY), 5);
        check_val("blue_both_chg", chg_seen, 0);

        // Repeat down on red, switch to green mid-repeat.
        tap(0); tap(0);
        check_val("h1_red_again", int'(H1), 1);
        BTN_DN = 1'b1; ticks(64);
        BTN_SEL = 1'b1; ticks(10);
        BTN_SEL = 1'b0; ticks(10);
        BTN_DN = 1'b0; ticks(12);
        check_val("sel_mid_red", int'(RED_DUTY), 7);
        check_val("sel_mid_green", int'(GREEN_DUTY), 2);
        check_val("sel_mid_h1", int'(H1), 2);

        // Reset in the middle of an UP repeat with the button still held.
        BTN_UP = 1'b1; ticks(70);
        async_clr();
        check_val("clr_h1", int'(H1), 0);
        check_val("clr_green", int'(GREEN_DUTY), 0);
        check_val("clr_chg", int'(CHG), 0);
        chg_seen = 0;
        ticks(7);
        check_val("clr_quiet", chg_seen, 0);
        ticks(30);
        BTN_UP = 1'b0; ticks(12);

        // Random buttons and tick pacing.
        rand_ce = 1'b1;
        for (int it = 0; it < 80; it++) begin
            int pick;
            pick = $urandom_range(0, 9);
            BTN_SEL = (pick == 0 || pick == 8);
            BTN_UP  = (pick inside {1, 2, 3, 7, 8});
            BTN_DN  = (pick inside {4, 5, 6, 7});
            if ($urandom_range(0, 19) == 0) async_clr();
            ticks($urandom_range(1, 40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
